// File: rtl/flow_step_ctrl_pkg.sv
// Shared types and defaults for the rotating-LED pacing controller.
package flow_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_e;

  localparam int SPEED_W = 2;

  localparam logic DIR_TO_LSB = 1'b0;
  localparam logic DIR_TO_MSB = 1'b1;

  localparam int DEF_BASE_DIV  = 50_000_000;
  localparam int DEF_DB_CYCLES = 1_000_000;

endpackage

// File: rtl/flow_step_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-level debouncer and
// a one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_WIDTH  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  logic                s1;
  logic                sync;
  logic [DB_WIDTH-1:0] cnt;
  logic                accept;

  // Accept once the synced input has disagreed for DB_CYCLES consecutive cycles.
  assign accept = (sync != level) && (cnt == DB_WIDTH'(DB_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      sync  <= s1;
      press <= accept && sync;
      if (sync == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/flow_step_ctrl.sv
// Step-strobe pacing for the rotating-LED shifter: run/pause, direction and
// four rates. Define SINGLE_STEP_EN to add the btn_step single-step button.
module flow_step_ctrl
  import flow_pkg::*;
#(
  parameter int BASE_DIV  = DEF_BASE_DIV,
  parameter int DIV_WIDTH = 26,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int DB_WIDTH  = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_pause,
  input  logic               btn_dir,
  input  logic [SPEED_W-1:0] speed,
`ifdef SINGLE_STEP_EN
  input  logic               btn_step,
`endif
  output logic               step,
  output logic               dir,
  output logic               running
);

  localparam logic [DIV_WIDTH-1:0] BASE = DIV_WIDTH'(BASE_DIV);

  state_e               state;
  state_e               state_next;
  logic                 pause_level;
  logic                 pause_press;
  logic                 dir_level;
  logic                 dir_press;
  logic [SPEED_W-1:0]   speed_s1;
  logic [SPEED_W-1:0]   speed_sync;
  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] period;
  logic [DIV_WIDTH-1:0] period_next;
  logic                 advance;
  logic                 terminal;
  logic                 run_step;
  logic                 single_step;
  logic                 unused_levels;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_WIDTH(DB_WIDTH)) u_db_pause (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_pause),
    .level (pause_level),
    .press (pause_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_WIDTH(DB_WIDTH)) u_db_dir (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_dir),
    .level (dir_level),
    .press (dir_press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_s1   <= '0;
      speed_sync <= '0;
    end else begin
      speed_s1   <= speed;
      speed_sync <= speed_s1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (pause_press) state_next = ST_PAUSE;
      ST_PAUSE: if (pause_press) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      dir   <= DIR_TO_LSB;
    end else begin
      state <= state_next;
      if (dir_press) dir <= ~dir;
    end
  end

  assign running = (state == ST_RUN);

  // A pause press freezes the count on its own cycle, so a press landing on
  // the terminal count leaves it at period-1 and the step fires on resume.
  assign period_next = BASE >> speed_sync;
  assign advance     = (state == ST_RUN) && !pause_press;
  assign terminal    = (count == period - DIV_WIDTH'(1));
  assign run_step    = advance && terminal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      period <= BASE;
    end else if (advance) begin
      if (terminal) begin
        count  <= '0;
        period <= period_next;
      end else begin
        count <= count + DIV_WIDTH'(1);
      end
    end
  end

`ifdef SINGLE_STEP_EN
  logic step_level;
  logic step_press;
  logic single_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_WIDTH(DB_WIDTH)) u_db_step (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_step),
    .level (step_level),
    .press (step_press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) single_q <= 1'b0;
    else     single_q <= step_press && (state == ST_PAUSE);
  end

  assign single_step   = single_q;
  assign unused_levels = ^{pause_level, dir_level, step_level};
`else
  assign single_step   = 1'b0;
  assign unused_levels = ^{pause_level, dir_level};
`endif

  assign step = run_step | single_step;

endmodule

// File: tb/tb_flow_step_ctrl.sv
// Scoreboard bench for flow_step_ctrl at BASE_DIV=16, DB_CYCLES=4: directed
// scenarios followed by randomized button/speed/reset activity.
module tb_flow_step_ctrl;
  import flow_pkg::*;

  localparam int BASE_DIV  = 16;
  localparam int DIV_WIDTH = 5;
  localparam int DB_CYCLES = 4;
  localparam int DB_WIDTH  = 3;
`ifdef SINGLE_STEP_EN
  localparam bit SS_EN = 1'b1;
`else
  localparam bit SS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_pause = 1'b0;
  logic       btn_dir = 1'b0;
  logic       btn_step = 1'b0;
  logic [1:0] speed = 2'b00;
  logic       step;
  logic       dir;
  logic       running;

  flow_step_ctrl #(
    .BASE_DIV (BASE_DIV),
    .DIV_WIDTH(DIV_WIDTH),
    .DB_CYCLES(DB_CYCLES),
    .DB_WIDTH (DB_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_pause(btn_pause),
    .btn_dir  (btn_dir),
    .speed    (speed),
`ifdef SINGLE_STEP_EN
    .btn_step (btn_step),
`endif
    .step     (step),
    .dir      (dir),
    .running  (running)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: expected {step, dir, running} for each clock interval
  logic [2:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  int         cyc = 0;

  // reference model: countdown to next step, window-based debounce
  int         m_rem;
  bit         m_run;
  bit         m_dir;
  bit         m_ss;
  logic [2:0] m_level;
  logic [2:0] m_press;
  logic [2:0] raw_q[$];
  logic [1:0] spd_q[$];
  logic [2:0] sync_q[$];

  task automatic model_reset();
    m_rem   = BASE_DIV;
    m_run   = 1'b1;
    m_dir   = 1'b0;
    m_ss    = 1'b0;
    m_level = 3'b000;
    m_press = 3'b000;
    raw_q.delete();
    spd_q.delete();
    sync_q.delete();
    repeat (2) begin
      raw_q.push_back(3'b000);
      spd_q.push_back(2'b00);
    end
  endtask

  // One active clock edge; raw_b/raw_s are the inputs held before the edge.
  task automatic model_edge(input logic [2:0] raw_b, input logic [1:0] raw_s);
    logic [2:0] syncv;
    logic [1:0] spd_sync;
    logic [2:0] prev_press;
    bit         prev_run;
    bit         all_diff;
    syncv    = raw_q[raw_q.size()-2];
    spd_sync = spd_q[spd_q.size()-2];
    raw_q.push_back(raw_b);
    spd_q.push_back(raw_s);
    while (raw_q.size() > 2) void'(raw_q.pop_front());
    while (spd_q.size() > 2) void'(spd_q.pop_front());
    sync_q.push_back(syncv);
    while (sync_q.size() > DB_CYCLES) void'(sync_q.pop_front());

    prev_press = m_press;
    prev_run   = m_run;
    if (m_run && !prev_press[0])
      m_rem = (m_rem == 1) ? (BASE_DIV >> spd_sync) : m_rem - 1;
    m_run = m_run ^ prev_press[0];
    m_dir = m_dir ^ prev_press[1];
    m_ss  = SS_EN && prev_press[2] && !prev_run;

    for (int b = 0; b < 3; b++) begin
      m_press[b] = 1'b0;
      if (sync_q.size() == DB_CYCLES) begin
        all_diff = 1'b1;
        foreach (sync_q[i]) if (sync_q[i][b] == m_level[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[b] = ~m_level[b];
          m_press[b] = m_level[b];
        end
      end
    end
  endtask

  function automatic logic [2:0] model_out();
    bit s;
    s = (m_run && m_rem == 1 && !m_press[0]) || m_ss;
    return {s, m_dir, m_run};
  endfunction

  // driver: one clock interval of stimulus; b = {step, dir, pause} buttons
  task automatic cycle(input logic r, input logic [2:0] b, input logic [1:0] s);
    logic [2:0] prev_b;
    logic [1:0] prev_s;
    logic       prev_r;
    prev_b = {btn_step, btn_dir, btn_pause};
    prev_s = speed;
    prev_r = rst;
    @(posedge clk);
    #1;
    if (prev_r) model_reset();
    else        model_edge(prev_b, prev_s);
    rst = r;
    {btn_step, btn_dir, btn_pause} = b;
    speed = s;
    if (r) model_reset();
    exp_q.push_back(model_out());
    cyc++;
  endtask

  task automatic hold(input int n, input logic [2:0] b, input logic [1:0] s);
    for (int i = 0; i < n; i++) cycle(1'b0, b, s);
  endtask

  // monitor
  always @(negedge clk) begin
    if (mon_en) begin
      logic [2:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL no_expect cycle=%0d got step/dir/run=%b", cyc, {step, dir, running});
      end else begin
        e = exp_q.pop_front();
        if ({step, dir, running} !== e) begin
          errors++;
          $display("FAIL outputs cycle=%0d step/dir/run got %b expected %b",
                   cyc, {step, dir, running}, e);
        end
      end
    end
  end

  logic [2:0] rb;
  logic [1:0] rs;
  int         hb[3];
  int         hs;
  int         hr;

  initial begin
    model_reset();
    cycle(1'b1, 3'b000, 2'd0);
    mon_en = 1'b1;
    cycle(1'b1, 3'b000, 2'd0);
    cycle(1'b0, 3'b000, 2'd0);

    // steady rate, then a mid-period speed change
    hold(40, 3'b000, 2'd0);
    hold(7, 3'b000, 2'd0);
    hold(30, 3'b000, 2'd2);
    hold(10, 3'b000, 2'd0);
    hold(20, 3'b000, 2'd0);

    // pause and resume with a long press
    hold(10, 3'b001, 2'd0);
    hold(25, 3'b000, 2'd0);
    hold(10, 3'b001, 2'd0);
    hold(30, 3'b000, 2'd0);

    // glitchy press shorter than the debounce window
    hold(3, 3'b001, 2'd0);
    hold(1, 3'b000, 2'd0);
    hold(2, 3'b001, 2'd0);
    hold(20, 3'b000, 2'd0);

    // direction toggles in RUN and in PAUSE
    hold(8, 3'b010, 2'd0);
    hold(20, 3'b000, 2'd0);
    hold(8, 3'b001, 2'd0);
    hold(12, 3'b000, 2'd0);
    hold(8, 3'b010, 2'd0);
    hold(12, 3'b000, 2'd0);
    hold(8, 3'b010, 2'd0);
    hold(12, 3'b000, 2'd0);

    // single-step presses while paused, then reset while paused with dir=1
    hold(6, 3'b100, 2'd0);
    hold(15, 3'b000, 2'd0);
    hold(6, 3'b100, 2'd0);
    hold(15, 3'b000, 2'd0);
    cycle(1'b1, 3'b000, 2'd0);
    cycle(1'b1, 3'b000, 2'd0);
    cycle(1'b0, 3'b000, 2'd0);
    hold(40, 3'b000, 2'd0);

    // randomized activity
    rb = 3'b000;
    rs = 2'd0;
    hs = 0;
    hr = 0;
    for (int b = 0; b < 3; b++) hb[b] = $urandom_range(5, 40);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hb[b] == 0) begin
          rb[b] = ~rb[b];
          hb[b] = rb[b] ? $urandom_range(1, DB_CYCLES + 4) : $urandom_range(1, 60);
        end else begin
          hb[b]--;
        end
      end
      if (hs == 0) begin
        rs = 2'($urandom_range(0, 3));
        hs = $urandom_range(5, 80);
      end else begin
        hs--;
      end
      if (hr == 0 && $urandom_range(0, 599) == 0) hr = $urandom_range(1, 3);
      if (hr > 0) begin
        cycle(1'b1, rb, rs);
        hr--;
      end else begin
        cycle(1'b0, rb, rs);
      end
    end
    hold(20, 3'b000, 2'd0);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain leftover=%0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
